pipelined_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 24 ++
 rtl/adder_stage.sv | 51 +++++
 rtl/pipelined_adder.sv | 144 ++++++++++++++
 tb/tb_pipelined_adder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined ripple-carry adder.
// Imported by adder_stage and pipelined_adder.
package adder_pkg;

  // Per-stage control record that travels with each chunk sum.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_rec_t;

  function automatic bit stages_divide_width(int unsigned width, int unsigned stages);
    return (stages != 0) && ((width % stages) == 0);
  endfunction

  function automatic bit params_ok(int unsigned width, int unsigned stages);
    return (width >= 1) && (stages >= 1) && stages_divide_width(width, stages);
  endfunction

  // Guarded so an illegal STAGES reaches the $fatal check instead of dividing by zero.
  function automatic int unsigned chunk_width(int unsigned width, int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-bit ripple-carry slice with registered sum, carry-out and valid.
// All registers advance only when en_i is high.
module adder_stage
  import adder_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic             valid_o,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o
);

  stage_rec_t       rec_q, rec_d;
  logic [CHUNK-1:0] sum_q, sum_d;
  logic [CHUNK:0]   carry;

  // Explicit full-adder chain, bit 0 fed by the incoming carry.
  always_comb begin
    carry    = '0;
    carry[0] = c_i;
    sum_d    = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum_d[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    rec_d.valid = valid_i;
    rec_d.carry = carry[CHUNK];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rec_q <= '0;
      sum_q <= '0;
    end else if (en_i) begin
      rec_q <= rec_d;
      sum_q <= sum_d;
    end
  end

  assign valid_o = rec_q.valid;
  assign c_o     = rec_q.carry;
  assign s_o     = sum_q;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES registered ripple chunks with valid/ready on both sides.
// Define PIPELINED_ADDER_SUB_EN to add the sub_i port and a - b support.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_param_check
    $fatal(1, "pipelined_adder: WIDTH and STAGES must be >= 1 and STAGES must divide WIDTH");
  end

  logic             en;
  logic             sub_in;
  logic             sub_stage [STAGES];
  logic [CHUNK-1:0] a_raw     [STAGES];
  logic [CHUNK-1:0] b_raw     [STAGES];
  logic [CHUNK-1:0] st_b      [STAGES];
  logic [CHUNK-1:0] st_sum    [STAGES];
  logic             st_cin    [STAGES];
  logic             st_cout   [STAGES];
  logic             st_vin    [STAGES];
  logic             st_vout   [STAGES];

  // A full output stalls everything, bubbles included, so order is never disturbed.
  assign en      = ~valid_o | ready_i;
  assign ready_o = en;
  assign valid_o = st_vout[STAGES-1];
  assign c_o     = st_cout[STAGES-1];

`ifdef PIPELINED_ADDER_SUB_EN
  assign sub_in = sub_i;
`else
  assign sub_in = 1'b0;
`endif

  // sub travels alongside b so each chunk inverts with its own transaction's select.
  assign sub_stage[0] = sub_in;
  if (STAGES > 1) begin : g_sub_skew
    logic sub_q [STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < STAGES - 1; i++) sub_q[i] <= 1'b0;
      end else if (en) begin
        sub_q[0] <= sub_in;
        for (int i = 1; i < STAGES - 1; i++) sub_q[i] <= sub_q[i-1];
      end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_tap
      assign sub_stage[k] = sub_q[k-1];
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_chunk
    // Chunk j reaches its stage j cycles after acceptance.
    if (j == 0) begin : g_direct
      assign a_raw[0] = a_i[CHUNK-1:0];
      assign b_raw[0] = b_i[CHUNK-1:0];
      assign st_cin[0] = sub_stage[0] | c_i;
      assign st_vin[0] = valid_i;
    end else begin : g_skew
      logic [CHUNK-1:0] a_q [j];
      logic [CHUNK-1:0] b_q [j];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < j; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
          end
        end else if (en) begin
          a_q[0] <= a_i[j*CHUNK +: CHUNK];
          b_q[0] <= b_i[j*CHUNK +: CHUNK];
          for (int i = 1; i < j; i++) begin
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
          end
        end
      end

      assign a_raw[j]  = a_q[j-1];
      assign b_raw[j]  = b_q[j-1];
      assign st_cin[j] = st_cout[j-1];
      assign st_vin[j] = st_vout[j-1];
    end

    assign st_b[j] = b_raw[j] ^ {CHUNK{sub_stage[j]}};

    adder_stage #(
      .CHUNK (CHUNK)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en),
      .valid_i (st_vin[j]),
      .a_i     (a_raw[j]),
      .b_i     (st_b[j]),
      .c_i     (st_cin[j]),
      .valid_o (st_vout[j]),
      .s_o     (st_sum[j]),
      .c_o     (st_cout[j])
    );

    // Lower chunks wait for the last stage so a whole sum leaves together.
    if (j == STAGES - 1) begin : g_last
      assign s_o[j*CHUNK +: CHUNK] = st_sum[j];
    end else begin : g_deskew
      localparam int unsigned Depth = STAGES - 1 - j;
      logic [CHUNK-1:0] s_q [Depth];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < Depth; i++) s_q[i] <= '0;
        end else if (en) begin
          s_q[0] <= st_sum[j];
          for (int i = 1; i < Depth; i++) s_q[i] <= s_q[i-1];
        end
      end

      assign s_o[j*CHUNK +: CHUNK] = s_q[Depth-1];
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=8, STAGES=2); covers sub_i when
// PIPELINED_ADDER_SUB_EN is defined.
module tb_pipelined_adder;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk;
  logic         rst;
  logic [W-1:0] a_i, b_i, s_o;
  logic         c_i, sub_i, valid_i, ready_i, ready_o, c_o, valid_o;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int results     = 0;
  bit chk_lat     = 1'b0;

  logic [W:0] exp_q[$];
  int         stamp_q[$];

  pipelined_adder #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .a_i     (a_i),
    .b_i     (b_i),
    .c_i     (c_i),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub_i   (sub_i),
`endif
    .valid_i (valid_i),
    .ready_o (ready_o),
    .s_o     (s_o),
    .c_o     (c_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic sb);
    if (sb) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // One cycle: drive at negedge, score any output transfer, record any input transfer.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic sb, input logic rdy);
    logic [W:0] e;
    int st;
    @(negedge clk);
    valid_i = v; a_i = a; b_i = b; c_i = c; sub_i = sb; ready_i = rdy;
    cyc++;
    #1;
    if (valid_o && ready_i) begin
      vectors++;
      results++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL result: unexpected output {c_o,s_o}=%h, none required", {c_o, s_o});
      end else begin
        e  = exp_q.pop_front();
        st = stamp_q.pop_front();
        if ({c_o, s_o} !== e) begin
          miscompares++;
          $display("FAIL result: got {c_o,s_o}=%h required %h", {c_o, s_o}, e);
        end
        if (chk_lat) begin
          vectors++;
          if (cyc - st != S) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles required %0d", cyc - st, S);
          end
        end
      end
    end
    if (valid_i && ready_o) begin
      exp_q.push_back(model(a, b, c, sb));
      stamp_q.push_back(cyc);
    end
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain: %0d results outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; c_i = 1'b0; sub_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors += 4;
    if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset valid_o: got %b required 0", valid_o); end
    if (s_o !== '0) begin miscompares++; $display("FAIL reset s_o: got %h required 00", s_o); end
    if (c_o !== 1'b0) begin miscompares++; $display("FAIL reset c_o: got %b required 0", c_o); end
    if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset ready_o: got %b required 1", ready_o); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      vectors += 2;
      if (valid_o !== 1'b0) begin miscompares++; $display("FAIL idle valid_o: got %b required 0", valid_o); end
      if (ready_o !== 1'b1) begin miscompares++; $display("FAIL idle ready_o: got %b required 1", ready_o); end
    end
  endtask

  task automatic test_carry();
    step(1'b1, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b1);
    repeat (S + 1) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_drained("carry");
  endtask

  task automatic test_stream();
    chk_lat = 1'b1;
    repeat (256) step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1);
    repeat (S + 1) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk_lat = 1'b0;
    check_drained("stream");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] av [4];
    logic [W-1:0] bv [4];
    int r0;
    for (int i = 0; i < 4; i++) begin
      av[i] = W'($urandom);
      bv[i] = W'($urandom);
    end
    r0 = results;
    step(1'b1, av[0], bv[0], 1'b0, 1'b0, 1'b1);
    step(1'b1, av[1], bv[1], 1'b1, 1'b0, 1'b1);
    repeat (3) begin
      step(1'b1, av[2], bv[2], 1'b0, 1'b0, 1'b0);
      vectors += 3;
      if (ready_o !== 1'b0) begin miscompares++; $display("FAIL stall ready_o: got %b required 0", ready_o); end
      if (valid_o !== 1'b1) begin miscompares++; $display("FAIL stall valid_o: got %b required 1", valid_o); end
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL stall hold: no result pending, required 2");
      end else if ({c_o, s_o} !== exp_q[0]) begin
        miscompares++;
        $display("FAIL stall hold: got {c_o,s_o}=%h required %h", {c_o, s_o}, exp_q[0]);
      end
    end
    step(1'b1, av[2], bv[2], 1'b0, 1'b0, 1'b1);
    step(1'b1, av[3], bv[3], 1'b1, 1'b0, 1'b1);
    repeat (S + 1) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_drained("backpressure");
    vectors++;
    if (results - r0 != 4) begin
      miscompares++;
      $display("FAIL backpressure count: got %0d results required 4", results - r0);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h56, 8'h78, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    rst = 1'b1;
    #1;
    vectors += 2;
    if (valid_o !== 1'b0) begin miscompares++; $display("FAIL midreset valid_o: got %b required 0", valid_o); end
    if (s_o !== '0) begin miscompares++; $display("FAIL midreset s_o: got %h required 00", s_o); end
    exp_q.delete();
    stamp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (valid_o !== 1'b0) begin miscompares++; $display("FAIL stale valid_o: got %b required 0", valid_o); end
    end
  endtask

`ifdef PIPELINED_ADDER_SUB_EN
  task automatic test_sub();
    step(1'b1, 8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h07, 8'h05, 1'b1, 1'b1, 1'b1);
    step(1'b1, 8'h07, 8'h05, 1'b1, 1'b0, 1'b1);
    repeat (S + 1) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_drained("sub");
  endtask
`endif

  initial begin
    test_reset();
    test_carry();
    test_stream();
    test_backpressure();
    test_mid_reset();
`ifdef PIPELINED_ADDER_SUB_EN
    test_sub();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
